adu_seq: RTL and testbench

- Sequencer/arbiter for the 16-bit address unit (adu), which latches a 16-bit address and drives it out one byte at a time on the 8-bit bus.
- Shares the adu between two requesters (requester 0 = fetch/PC path, requester 1 = data-pointer path) using round-robin arbitration.
- For each granted request it generates the adu control sequence: write-enable, then low-byte read, then high-byte read, each byte gated by oe.
- Sits between the CPU control unit and the adu instance; the adu's q output goes straight to the byte bus, and this block provides the byte-valid handshake around it.

---
 rtl/adu_seq_pkg.sv | 19 +
 rtl/adu_seq_rr_arb2.sv | 21 ++
 rtl/adu_seq.sv | 109 ++++++++++
 tb/tb_adu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adu_seq_pkg.sv
// Shared definitions for the adu sequencer: state encoding, requester IDs
// and default widths.
package adu_seq_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam int REQ_PC = 0;
    localparam int REQ_DP = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_B0   = 3'd2,
        ST_B1   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/adu_seq_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the requester that wins
// when both request at once.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/adu_seq.sv
// Sequencer for the shared 16-bit address unit: arbitrates two requesters
// and steps the adu through load, first byte, second byte and completion.
module adu_seq
    import adu_seq_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter bit HI_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          busy,
    input  logic          bus_rdy,
    output logic          byte_vld,
    output logic [AW-1:0] adu_a,
    output logic          adu_we,
    output logic          adu_rl,
    output logic          adu_rh,
    output logic          adu_oe
);

    if (AW != 2 * DW) begin : g_width_check
        $error("adu_seq: AW must be exactly twice DW");
    end

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [AW-1:0] a_q, a_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    arb_gnt;
    logic          in_b0, in_b1;

    rr_arb2 u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .enable (state_q == ST_IDLE),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            a_q     <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            ptr_q   <= ptr_d;
        end
    end

    // The address and grant are captured only on the IDLE edge, so requesters
    // may drop req or change their address freely once granted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    a_d     = arb_gnt[REQ_DP] ? addr1 : addr0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_B0;
            ST_B0: begin
                if (bus_rdy) state_d = ST_B1;
            end
            ST_B1: begin
                if (bus_rdy) state_d = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = gnt_q[REQ_PC] ? 1'(REQ_DP) : 1'(REQ_PC);
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every adu control is a pure decode of registered state, so neither req
    // nor bus_rdy has a combinational path to the adu.
    always_comb begin
        in_b0    = (state_q == ST_B0);
        in_b1    = (state_q == ST_B1);
        busy     = (state_q != ST_IDLE);
        gnt      = gnt_q;
        done     = (state_q == ST_DONE) ? gnt_q : 2'b00;
        adu_a    = a_q;
        adu_we   = (state_q == ST_LOAD);
        adu_oe   = in_b0 | in_b1;
        byte_vld = in_b0 | in_b1;
        adu_rl   = HI_FIRST ? in_b1 : in_b0;
        adu_rh   = HI_FIRST ? in_b0 : in_b1;
    end

endmodule

// File: tb/tb_adu_seq.sv
// Bench for adu_seq: two instances (low-first and high-first) driven in
// lockstep, each checked every cycle against a transaction-level model.
module tb_adu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] addr0, addr1;
    logic        bus_rdy;

    logic [1:0]  gnt_lo, done_lo, gnt_hi, done_hi;
    logic        busy_lo, vld_lo, we_lo, rl_lo, rh_lo, oe_lo;
    logic        busy_hi, vld_hi, we_hi, rl_hi, rh_hi, oe_hi;
    logic [15:0] a_lo, a_hi;
    logic [15:0] adu_reg_lo, adu_reg_hi;
    logic [7:0]  q_lo, q_hi;

    logic [7:0]  log_lo[$];
    logic [7:0]  log_hi[$];

    int          m_step;
    logic        m_win;
    logic [15:0] m_addr;
    logic        m_ptr;

    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    adu_seq #(.AW(16), .DW(8), .HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
        .gnt(gnt_lo), .done(done_lo), .busy(busy_lo), .bus_rdy(bus_rdy),
        .byte_vld(vld_lo), .adu_a(a_lo), .adu_we(we_lo), .adu_rl(rl_lo),
        .adu_rh(rh_lo), .adu_oe(oe_lo)
    );

    adu_seq #(.AW(16), .DW(8), .HI_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
        .gnt(gnt_hi), .done(done_hi), .busy(busy_hi), .bus_rdy(bus_rdy),
        .byte_vld(vld_hi), .adu_a(a_hi), .adu_we(we_hi), .adu_rl(rl_hi),
        .adu_rh(rh_hi), .adu_oe(oe_hi)
    );

    // Behavioural adu: latches the address on we and drives the selected byte.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            adu_reg_lo <= 16'h0000;
            adu_reg_hi <= 16'h0000;
        end else begin
            if (we_lo) adu_reg_lo <= a_lo;
            if (we_hi) adu_reg_hi <= a_hi;
        end
    end

    assign q_lo = oe_lo ? (rl_lo ? adu_reg_lo[7:0] : (rh_lo ? adu_reg_lo[15:8] : 8'h00)) : 8'h00;
    assign q_hi = oe_hi ? (rl_hi ? adu_reg_hi[7:0] : (rh_hi ? adu_reg_hi[15:8] : 8'h00)) : 8'h00;

    // Record every byte the bus consumer actually accepts.
    always @(posedge clk) begin
        if (!rst && bus_rdy) begin
            if (vld_lo) log_lo.push_back(q_lo);
            if (vld_hi) log_hi.push_back(q_hi);
        end
    end

    // Model position in a transaction: 0 idle, 1 load, 2 first byte,
    // 3 second byte, 4 completion.
    task automatic resetModel();
        m_step = 0;
        m_win  = 1'b0;
        m_addr = 16'h0000;
        m_ptr  = 1'b0;
    endtask

    task automatic modelUpdate();
        if (rst) begin
            resetModel();
        end else begin
            case (m_step)
                0: if (req != 2'b00) begin
                    m_win  = (req == 2'b11) ? m_ptr : req[1];
                    m_addr = m_win ? addr1 : addr0;
                    m_step = 1;
                end
                1: m_step = 2;
                2: if (bus_rdy) m_step = 3;
                3: if (bus_rdy) m_step = 4;
                default: begin
                    m_ptr  = ~m_win;
                    m_step = 0;
                end
            endcase
        end
    endtask

    function automatic logic [33:0] expVec(input bit hi_first);
        logic       vs, sel_hi, rl_e, rh_e;
        logic [1:0] gnt_e, done_e;
        logic [7:0] q_e;
        vs     = (m_step == 2) || (m_step == 3);
        sel_hi = (m_step == 2) ? hi_first : ~hi_first;
        rl_e   = vs && !sel_hi;
        rh_e   = vs && sel_hi;
        q_e    = vs ? (sel_hi ? m_addr[15:8] : m_addr[7:0]) : 8'h00;
        gnt_e  = (m_step != 0) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
        done_e = (m_step == 4) ? gnt_e : 2'b00;
        return {gnt_e, done_e, m_step != 0, vs, m_addr, m_step == 1, rl_e, rh_e, vs, q_e};
    endfunction

    task automatic checkOutput(input string tag);
        logic [33:0] obs, exp_v;
        obs   = {gnt_lo, done_lo, busy_lo, vld_lo, a_lo, we_lo, rl_lo, rh_lo, oe_lo, q_lo};
        exp_v = expVec(1'b0);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s/lo_first obs=%h exp=%h", tag, obs, exp_v);
        end
        obs   = {gnt_hi, done_hi, busy_hi, vld_hi, a_hi, we_hi, rl_hi, rh_hi, oe_hi, q_hi};
        exp_v = expVec(1'b1);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s/hi_first obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic br, input string tag);
        req     = r;
        bus_rdy = br;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Compares the accepted byte stream of each instance with a fixed sequence.
    task automatic checkBytes(input string tag, input int n,
                              input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        logic [31:0] p;
        p = 32'h0;
        foreach (log_lo[i]) p = {p[23:0], log_lo[i]};
        vectors++;
        assert (log_lo.size() == n && p === exp_lo) else begin
            miscompares++;
            $error("[TB] FAIL %s/lo_bytes obs=%h (n=%0d) exp=%h (n=%0d)", tag, p, log_lo.size(), exp_lo, n);
        end
        p = 32'h0;
        foreach (log_hi[i]) p = {p[23:0], log_hi[i]};
        vectors++;
        assert (log_hi.size() == n && p === exp_hi) else begin
            miscompares++;
            $error("[TB] FAIL %s/hi_bytes obs=%h (n=%0d) exp=%h (n=%0d)", tag, p, log_hi.size(), exp_hi, n);
        end
        log_lo.delete();
        log_hi.delete();
    endtask

    initial begin
        rst     = 1'b1;
        req     = 2'b00;
        bus_rdy = 1'b0;
        addr0   = 16'h0000;
        addr1   = 16'h0000;
        #1;
        resetModel();
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle with no requests");
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b1, "idle");

        $display("[TB] contention, both requesters held");
        addr0 = 16'h1234;
        addr1 = 16'h4E20;
        for (int i = 0; i < 9; i++) applyStimulus(2'b11, 1'b1, "contend");
        applyStimulus(2'b00, 1'b1, "contend_end");
        checkBytes("contend", 4, 32'h3412204E, 32'h12344E20);

        $display("[TB] single request");
        addr0 = 16'h7A0E;
        for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b1, "single");
        applyStimulus(2'b00, 1'b1, "single_end");
        checkBytes("single", 2, 32'h00000E7A, 32'h00007A0E);

        $display("[TB] stall in first byte");
        addr0 = 16'hA55A;
        applyStimulus(2'b01, 1'b1, "stall");
        applyStimulus(2'b01, 1'b1, "stall");
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, "stall_hold");
        applyStimulus(2'b01, 1'b1, "stall");
        applyStimulus(2'b01, 1'b1, "stall");
        applyStimulus(2'b00, 1'b1, "stall_end");
        checkBytes("stall", 2, 32'h00005AA5, 32'h0000A55A);

        $display("[TB] byte order");
        addr0 = 16'hBEEF;
        for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b1, "order");
        applyStimulus(2'b00, 1'b1, "order_end");
        checkBytes("order", 2, 32'h0000EFBE, 32'h0000BEEF);

        $display("[TB] request withdrawn after grant");
        addr1 = 16'h2468;
        applyStimulus(2'b10, 1'b1, "withdraw");
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1'b1, "withdraw");
        checkBytes("withdraw", 2, 32'h00006824, 32'h00002468);

        $display("[TB] address change after grant");
        addr0 = 16'h1357;
        applyStimulus(2'b01, 1'b1, "addr_hold");
        applyStimulus(2'b01, 1'b1, "addr_hold");
        addr0 = 16'hFFFF;
        applyStimulus(2'b01, 1'b1, "addr_hold");
        applyStimulus(2'b01, 1'b1, "addr_hold");
        applyStimulus(2'b00, 1'b1, "addr_hold_end");
        checkBytes("addr_hold", 2, 32'h00005713, 32'h00001357);

        $display("[TB] reset during second byte");
        addr0 = 16'h3C4B;
        addr1 = 16'h2222;
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b1, "pre_rst");
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("rst_async");
        @(negedge clk);
        checkOutput("rst_held");
        rst = 1'b0;
        log_lo.delete();
        log_hi.delete();
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b1, "post_rst");
        applyStimulus(2'b00, 1'b1, "post_rst_end");
        checkBytes("post_rst", 2, 32'h00004B3C, 32'h00003C4B);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
